jmp_cond_unit: RTL and testbench
================================

# jmp_cond_unit

Parametrised, registered successor to the PLC core's jump-condition multiplexer. It evaluates the jump condition of a jump instruction against a configurable vector of unit flags: bit-unit accumulator, word-unit overflow, comparator, semaphore, timer and any added flags. It adds edge-triggered jumps through sticky per-flag edge latches, and hardware loop counters with load and decrement-and-jump-if-nonzero operations. It sits between the instruction decoder (ROM data) and the program-counter load logic of each core.

## Interface

Parameters:
- FLAG_COUNT, 5, number of condition flags; legal range 1..31.
- LOOP_COUNT, 4, number of loop counters; legal range 1..4.
- LOOP_WIDTH, 16, width of each loop counter and of the operand.

Ports:
- CLK  in  1  single core clock; all state updates on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- ROM_InputData  in  8  jump opcode field; sampled when JMP_REQ=1.
- ROM_Operand  in  LOOP_WIDTH  load value for the loop LOAD operation.
- JMP_REQ  in  1  a jump instruction is present this cycle.
- FLAGS  in  FLAG_COUNT  live condition flags; bit 0 = BIT_UNIT_A, 1 = WORD_UNIT_OV, 2 = comparator result, 3 = semaphore, 4 = timer.
- JMPMUX_JMP_EN  out  1  jump taken; registered one-cycle pulse.
- JMPMUX_VALID  out  1  result of a request is on JMPMUX_JMP_EN; registered one-cycle pulse.
- JMPMUX_ILLEGAL  out  1  the request selected a nonexistent flag or counter; registered one-cycle pulse.

## Operation

Opcode decode, ROM_InputData[7:0]:
- [7:6] mode: 00 = level, 01 = rising edge, 10 = falling edge, 11 = loop.
- [5] INV: inverts the condition in level and edge modes. In loop mode it selects the operation: 0 = DJNZ, 1 = LOAD.
- [4:0] SEL: flag index in level and edge modes. In loop mode, SEL[1:0] is the counter index and SEL[4:2] must be 0.

Level mode:
- SEL = 31: unconditional jump; INV is ignored and the jump is taken.
- SEL < FLAG_COUNT: taken = FLAGS[SEL] XOR INV.
- Any other SEL: not taken, and JMPMUX_ILLEGAL is asserted.

Edge modes:
- edge_rise[i] = FLAGS[i] & ~prev[i]; edge_fall[i] = ~FLAGS[i] & prev[i].
- prev is the FLAGS value registered each cycle.
- Each edge sets a sticky latch: pend_rise[i] or pend_fall[i].
- cond = pend[SEL] | edge[SEL], so an edge occurring in the request cycle counts.
- taken = cond XOR INV.
- The request consumes (clears) the selected latch whether or not the jump is taken.
- If a new edge on the same flag and polarity occurs in the cycle after the consuming one, it is latched normally.
- If set and consume coincide, the consume wins, because the coincident edge is already counted in cond.
- SEL = 31 or SEL ≥ FLAG_COUNT: illegal, not taken, no latch change.
- Edge detection is masked in the first clock after reset release. prev is loaded in that clock, so a flag already high does not produce a spurious rising edge.

Loop mode:
- LOAD: cnt[k] := ROM_Operand; not taken.
- DJNZ with cnt[k] > 1: cnt[k] := cnt[k]−1; taken.
- DJNZ with cnt[k] = 1: cnt[k] := 0; not taken.
- DJNZ with cnt[k] = 0: saturates at 0; not taken. The counter never wraps.
- k ≥ LOOP_COUNT or SEL[4:2] ≠ 0: illegal, not taken, no counter change.

Requests and reset:
- JMP_REQ=0: no counter or latch consumption. Edge latches still accumulate and prev still updates.
- Reset mid-operation: all state clears immediately, and any result in flight is lost; no VALID is produced for it.
- Reset values: JMPMUX_JMP_EN=0, JMPMUX_VALID=0, JMPMUX_ILLEGAL=0, cnt[*]=0, pend_rise/pend_fall=0, prev=0, edge mask armed.

## Timing

- Latency is 1 cycle. A request sampled at rising edge n drives VALID, JMP_EN and ILLEGAL high for exactly the cycle following edge n.
- All outputs are 0 in cycles with no preceding request.
- Throughput is one request per cycle, with no stall and no backpressure.
- On back-to-back DJNZ to the same counter, the second request sees the already-decremented value.
- Flags are sampled at the same edge as JMP_REQ; there is no flag-to-result path outside the register.
- JMPMUX_ILLEGAL and JMPMUX_JMP_EN are never both 1.

## Test plan

- **Level mode:** FLAGS=5'b00100, opcode 8'h02 then 8'h22 on consecutive cycles → JMP_EN=1 then 0, VALID=1 both cycles. Opcode 8'h1F → JMP_EN=1 regardless of FLAGS. Opcode 8'h07 → ILLEGAL=1, JMP_EN=0.
- **Edge latching:** pulse FLAGS[4] 0→1→0 with no request, wait 3 cycles, then opcode 8'h44 → JMP_EN=1. Repeat 8'h44 immediately → JMP_EN=0 (latch consumed). Opcode 8'h84 → JMP_EN=1 (falling edge latched).
- **Coincident edge:** FLAGS[0] rises in the same cycle as request 8'h40 → JMP_EN=1 and the latch is clear afterwards. The next 8'h40 without a new edge → 0.
- **Loop:** LOAD counter 2 with operand 3 (8'hE2), then DJNZ 8'hC2 four times → JMP_EN sequence 1,1,0,0 and counter 0 at the end. Counter index 5 (8'hC5) → ILLEGAL=1.
- **Reset:** FLAGS[1]=1 held through reset release, then 8'h41 → JMP_EN=0 (no spurious edge). Assert RST_n low in the cycle after a request → VALID drops to 0 asynchronously and all counters read as 0 after a subsequent DJNZ (JMP_EN=0).
- **Throughput:** 8 consecutive requests with mixed modes → 8 consecutive VALID pulses, each matching a reference model cycle-for-cycle.

Source files
------------

// File: rtl/jmp_cond_unit.sv
// jmp_cond_unit
// Registered jump-condition evaluator for the PLC core. Decodes the jump
// opcode from ROM, checks the selected condition and drives a one-cycle
// result to the program-counter load logic. Supported conditions are flag
// level, latched rising/falling flag edges, and hardware loop counters
// with LOAD and DJNZ.
//
// Opcode layout (ROM_InputData):
//   [7:6] mode : 00 level, 01 rising edge, 10 falling edge, 11 loop
//   [5]   INV  : invert condition (level/edge); loop: 0 = DJNZ, 1 = LOAD
//   [4:0] SEL  : flag index (level/edge); loop: counter in [1:0], [4:2] = 0

module jmp_cond_unit #(
    parameter int FLAG_COUNT = 5,
    parameter int LOOP_COUNT = 4,
    parameter int LOOP_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [7:0]            ROM_InputData,
    input  logic [LOOP_WIDTH-1:0] ROM_Operand,
    input  logic                  JMP_REQ,
    input  logic [FLAG_COUNT-1:0] FLAGS,
    output logic                  JMPMUX_JMP_EN,
    output logic                  JMPMUX_VALID,
    output logic                  JMPMUX_ILLEGAL
);

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_LOOP  = 2'b11
    } mode_e;

    // Flag indices below this limit exist; SEL = 31 is always outside it
    // because FLAG_COUNT is at most 31.
    localparam logic [4:0] FLAG_LIMIT = 5'(FLAG_COUNT);
    localparam logic [2:0] LOOP_LIMIT = 3'(LOOP_COUNT);
    localparam logic [4:0] SEL_ALWAYS = 5'd31;
    localparam logic [LOOP_WIDTH-1:0] CNT_ONE  = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LOOP_WIDTH-1:0] CNT_ZERO = {LOOP_WIDTH{1'b0}};

    // Opcode fields
    mode_e       mode_s;
    logic        inv_s;
    logic [4:0]  sel_s;
    logic [1:0]  cnt_idx_s;

    assign mode_s    = mode_e'(ROM_InputData[7:6]);
    assign inv_s     = ROM_InputData[5];
    assign sel_s     = ROM_InputData[4:0];
    assign cnt_idx_s = ROM_InputData[1:0];

    // Edge tracking state
    logic [FLAG_COUNT-1:0] prev_q;
    logic                  edge_mask_q;
    logic [FLAG_COUNT-1:0] pend_rise_q;
    logic [FLAG_COUNT-1:0] pend_rise_d;
    logic [FLAG_COUNT-1:0] pend_fall_q;
    logic [FLAG_COUNT-1:0] pend_fall_d;
    logic [FLAG_COUNT-1:0] edge_rise_s;
    logic [FLAG_COUNT-1:0] edge_fall_s;

    // Loop counters; storage is always four entries so the 2-bit counter
    // index never goes out of range. Entries at or above LOOP_COUNT are
    // never written and stay zero.
    logic [LOOP_WIDTH-1:0] cnt_q [0:3];
    logic [LOOP_WIDTH-1:0] cnt_d [0:3];
    logic [LOOP_WIDTH-1:0] cur_cnt_s;

    // Zero-extended views so a 5-bit SEL can index any flag vector safely
    logic [31:0] flags_ext_s;
    logic [31:0] rise_cond_ext_s;
    logic [31:0] fall_cond_ext_s;
    logic [31:0] sel_onehot_s;
    logic [FLAG_COUNT-1:0] sel_clr_s;

    logic flag_ok_s;
    logic loop_ok_s;

    // Result of the current request, registered into the outputs
    logic taken_s;
    logic illegal_s;

    logic jmp_en_q;
    logic valid_q;
    logic illegal_q;

    assign flag_ok_s    = (sel_s < FLAG_LIMIT);
    assign loop_ok_s    = (sel_s[4:2] == 3'b000) && ({1'b0, cnt_idx_s} < LOOP_LIMIT);
    assign cur_cnt_s    = cnt_q[cnt_idx_s];
    assign sel_onehot_s = 32'd1 << sel_s;
    assign sel_clr_s    = sel_onehot_s[FLAG_COUNT-1:0];

    // Edge detection against the previous-cycle flags, suppressed in the
    // first clock after reset while prev is still being loaded.
    always_comb begin
        edge_rise_s = '0;
        edge_fall_s = '0;
        if (edge_mask_q) begin
            edge_rise_s = '0;
            edge_fall_s = '0;
        end else begin
            edge_rise_s = FLAGS & ~prev_q;
            edge_fall_s = ~FLAGS & prev_q;
        end
    end

    // Edge condition includes an edge in the request cycle itself
    always_comb begin
        flags_ext_s     = 32'(FLAGS);
        rise_cond_ext_s = 32'(pend_rise_q | edge_rise_s);
        fall_cond_ext_s = 32'(pend_fall_q | edge_fall_s);
    end

    // Request decode: condition evaluation, latch consumption, counter ops
    always_comb begin
        taken_s     = 1'b0;
        illegal_s   = 1'b0;
        pend_rise_d = pend_rise_q | edge_rise_s;
        pend_fall_d = pend_fall_q | edge_fall_s;
        cnt_d       = cnt_q;

        if (JMP_REQ) begin
            case (mode_s)
                MODE_LEVEL: begin
                    if (sel_s == SEL_ALWAYS) begin
                        taken_s = 1'b1;
                    end else if (flag_ok_s) begin
                        taken_s = flags_ext_s[sel_s] ^ inv_s;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                MODE_RISE: begin
                    if (flag_ok_s) begin
                        // Consume wins over a coincident set: that edge is
                        // already part of the condition.
                        taken_s     = rise_cond_ext_s[sel_s] ^ inv_s;
                        pend_rise_d = (pend_rise_q | edge_rise_s) & ~sel_clr_s;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                MODE_FALL: begin
                    if (flag_ok_s) begin
                        taken_s     = fall_cond_ext_s[sel_s] ^ inv_s;
                        pend_fall_d = (pend_fall_q | edge_fall_s) & ~sel_clr_s;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                MODE_LOOP: begin
                    if (!loop_ok_s) begin
                        illegal_s = 1'b1;
                    end else if (inv_s) begin
                        cnt_d[cnt_idx_s] = ROM_Operand;
                    end else if (cur_cnt_s > CNT_ONE) begin
                        cnt_d[cnt_idx_s] = cur_cnt_s - CNT_ONE;
                        taken_s          = 1'b1;
                    end else begin
                        // 1 reaches 0 without jumping; 0 saturates.
                        cnt_d[cnt_idx_s] = CNT_ZERO;
                    end
                end
                default: begin
                    taken_s   = 1'b0;
                    illegal_s = 1'b0;
                end
            endcase
        end else begin
            taken_s   = 1'b0;
            illegal_s = 1'b0;
        end
    end

    // Previous-flag register and one-shot edge mask after reset release
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            prev_q      <= '0;
            edge_mask_q <= 1'b1;
        end else begin
            prev_q      <= FLAGS;
            edge_mask_q <= 1'b0;
        end
    end

    // Sticky edge latches
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pend_rise_q <= '0;
            pend_fall_q <= '0;
        end else begin
            pend_rise_q <= pend_rise_d;
            pend_fall_q <= pend_fall_d;
        end
    end

    // Loop counters
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Registered one-cycle result pulses; illegal requests never jump
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            jmp_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            jmp_en_q  <= JMP_REQ & taken_s & ~illegal_s;
            valid_q   <= JMP_REQ;
            illegal_q <= JMP_REQ & illegal_s;
        end
    end

    assign JMPMUX_JMP_EN  = jmp_en_q;
    assign JMPMUX_VALID   = valid_q;
    assign JMPMUX_ILLEGAL = illegal_q;

endmodule

// File: tb/tb_jmp_cond_unit.sv
// Directed testbench for jmp_cond_unit: hand-computed expected results for
// level, edge, loop, reset and back-to-back request sequences.

module tb_jmp_cond_unit;

    logic        CLK;
    logic        RST_n;
    logic [7:0]  ROM_InputData;
    logic [15:0] ROM_Operand;
    logic        JMP_REQ;
    logic [4:0]  FLAGS;
    logic        JMPMUX_JMP_EN;
    logic        JMPMUX_VALID;
    logic        JMPMUX_ILLEGAL;

    int n_vec;
    int n_bad;

    jmp_cond_unit #(
        .FLAG_COUNT(5),
        .LOOP_COUNT(4),
        .LOOP_WIDTH(16)
    ) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .ROM_InputData  (ROM_InputData),
        .ROM_Operand    (ROM_Operand),
        .JMP_REQ        (JMP_REQ),
        .FLAGS          (FLAGS),
        .JMPMUX_JMP_EN  (JMPMUX_JMP_EN),
        .JMPMUX_VALID   (JMPMUX_VALID),
        .JMPMUX_ILLEGAL (JMPMUX_ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, let the rising edge take them, and return
    // 1 time unit later so the registered result can be sampled.
    task automatic step(input logic [4:0] flags, input logic req,
                        input logic [7:0] op, input logic [15:0] operand);
        FLAGS         = flags;
        JMP_REQ       = req;
        ROM_InputData = op;
        ROM_Operand   = operand;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_n   = 1'b0;
        JMP_REQ = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    task automatic test_reset();
        if (JMPMUX_VALID !== 1'b0 || JMPMUX_JMP_EN !== 1'b0 || JMPMUX_ILLEGAL !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got v/en/ill=%b%b%b want 000", JMPMUX_VALID, JMPMUX_JMP_EN, JMPMUX_ILLEGAL);
        end
        n_vec++;
        step(5'b00000, 1'b0, 8'h00, 16'h0);
        if (JMPMUX_VALID !== 1'b0 || JMPMUX_JMP_EN !== 1'b0 || JMPMUX_ILLEGAL !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle got v/en/ill=%b%b%b want 000", JMPMUX_VALID, JMPMUX_JMP_EN, JMPMUX_ILLEGAL);
        end
        n_vec++;
    endtask

    task automatic test_level();
        logic [7:0] ops  [8] = '{8'h02, 8'h22, 8'h1F, 8'h3F, 8'h07, 8'h01, 8'h04, 8'h05};
        logic       en   [8] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        logic       ill  [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 8; i++) begin
            step(5'b00100, 1'b1, ops[i], 16'h0);
            if (JMPMUX_JMP_EN !== en[i]) begin
                n_bad++;
                $display("FAIL level[%0d] op=%h jmp_en got %b want %b", i, ops[i], JMPMUX_JMP_EN, en[i]);
            end
            n_vec++;
            if (JMPMUX_VALID !== 1'b1 || JMPMUX_ILLEGAL !== ill[i]) begin
                n_bad++;
                $display("FAIL level[%0d] op=%h valid/illegal got %b%b want 1%b", i, ops[i], JMPMUX_VALID, JMPMUX_ILLEGAL, ill[i]);
            end
            n_vec++;
        end
        step(5'b00100, 1'b0, 8'h1F, 16'h0);
        if (JMPMUX_VALID !== 1'b0 || JMPMUX_JMP_EN !== 1'b0 || JMPMUX_ILLEGAL !== 1'b0) begin
            n_bad++;
            $display("FAIL level_idle got v/en/ill=%b%b%b want 000", JMPMUX_VALID, JMPMUX_JMP_EN, JMPMUX_ILLEGAL);
        end
        n_vec++;
    endtask

    task automatic test_edge_latch();
        logic [7:0] ops [6] = '{8'h44, 8'h44, 8'h84, 8'h64, 8'h45, 8'h5F};
        logic       en  [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        logic       ill [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        step(5'b00000, 1'b0, 8'h00, 16'h0);
        step(5'b10000, 1'b0, 8'h00, 16'h0);
        step(5'b00000, 1'b0, 8'h00, 16'h0);
        for (int i = 0; i < 3; i++) step(5'b00000, 1'b0, 8'h00, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step(5'b00000, 1'b1, ops[i], 16'h0);
            if (JMPMUX_JMP_EN !== en[i] || JMPMUX_ILLEGAL !== ill[i]) begin
                n_bad++;
                $display("FAIL edge[%0d] op=%h en/ill got %b%b want %b%b", i, ops[i], JMPMUX_JMP_EN, JMPMUX_ILLEGAL, en[i], ill[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_coincident_edge();
        step(5'b00001, 1'b1, 8'h40, 16'h0);
        if (JMPMUX_JMP_EN !== 1'b1) begin
            n_bad++;
            $display("FAIL coincident_first jmp_en got %b want 1", JMPMUX_JMP_EN);
        end
        n_vec++;
        step(5'b00001, 1'b1, 8'h40, 16'h0);
        if (JMPMUX_JMP_EN !== 1'b0 || JMPMUX_VALID !== 1'b1) begin
            n_bad++;
            $display("FAIL coincident_second en/valid got %b%b want 01", JMPMUX_JMP_EN, JMPMUX_VALID);
        end
        n_vec++;
    endtask

    task automatic test_loop();
        logic [7:0] ops [7] = '{8'hE2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC5};
        logic       en  [7] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        logic       ill [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 7; i++) begin
            step(5'b00000, 1'b1, ops[i], 16'd3);
            if (JMPMUX_JMP_EN !== en[i] || JMPMUX_ILLEGAL !== ill[i] || JMPMUX_VALID !== 1'b1) begin
                n_bad++;
                $display("FAIL loop[%0d] op=%h en/ill/valid got %b%b%b want %b%b1", i, ops[i],
                         JMPMUX_JMP_EN, JMPMUX_ILLEGAL, JMPMUX_VALID, en[i], ill[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] fl  [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        logic [7:0] ops [8] = '{8'hE1,    8'h40,    8'hC1,    8'hC1,    8'h00,    8'h80,    8'h1F,    8'h9F};
        logic       en  [8] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
        logic       ill [8] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
        do_reset();
        step(5'b00000, 1'b0, 8'h00, 16'h0);
        step(5'b00000, 1'b0, 8'h00, 16'h0);
        for (int i = 0; i < 8; i++) begin
            step(fl[i], 1'b1, ops[i], 16'd2);
            if (JMPMUX_VALID !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b[%0d] valid got %b want 1", i, JMPMUX_VALID);
            end
            n_vec++;
            if (JMPMUX_JMP_EN !== en[i] || JMPMUX_ILLEGAL !== ill[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d] op=%h en/ill got %b%b want %b%b", i, ops[i], JMPMUX_JMP_EN, JMPMUX_ILLEGAL, en[i], ill[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid();
        step(5'b00000, 1'b1, 8'hE0, 16'd5);
        step(5'b00000, 1'b1, 8'hC0, 16'd0);
        if (JMPMUX_VALID !== 1'b1 || JMPMUX_JMP_EN !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_before valid/en got %b%b want 11", JMPMUX_VALID, JMPMUX_JMP_EN);
        end
        n_vec++;
        JMP_REQ = 1'b0;
        RST_n   = 1'b0;
        #1;
        if (JMPMUX_VALID !== 1'b0 || JMPMUX_JMP_EN !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async valid/en got %b%b want 00", JMPMUX_VALID, JMPMUX_JMP_EN);
        end
        n_vec++;
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        step(5'b00000, 1'b1, 8'hC0, 16'd0);
        if (JMPMUX_VALID !== 1'b1 || JMPMUX_JMP_EN !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_cnt_cleared valid/en got %b%b want 10", JMPMUX_VALID, JMPMUX_JMP_EN);
        end
        n_vec++;
    endtask

    task automatic test_reset_no_spurious_edge();
        FLAGS = 5'b00010;
        do_reset();
        step(5'b00010, 1'b1, 8'h41, 16'h0);
        if (JMPMUX_VALID !== 1'b1 || JMPMUX_JMP_EN !== 1'b0) begin
            n_bad++;
            $display("FAIL no_spurious_edge valid/en got %b%b want 10", JMPMUX_VALID, JMPMUX_JMP_EN);
        end
        n_vec++;
        step(5'b00010, 1'b1, 8'h41, 16'h0);
        if (JMPMUX_JMP_EN !== 1'b0) begin
            n_bad++;
            $display("FAIL no_spurious_edge_later jmp_en got %b want 0", JMPMUX_JMP_EN);
        end
        n_vec++;
    endtask

    initial begin
        n_vec         = 0;
        n_bad         = 0;
        FLAGS         = 5'b00000;
        JMP_REQ       = 1'b0;
        ROM_InputData = 8'h00;
        ROM_Operand   = 16'h0000;
        do_reset();
        test_reset();
        test_level();
        test_edge_latch();
        test_coincident_edge();
        test_loop();
        test_back_to_back();
        test_reset_mid();
        test_reset_no_spurious_edge();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
